// File: rtl/alu_seq_core.sv
// Sequential ALU. Most ops finish in one cycle. MUL is an iterative shift-add and DIV is a restoring divider, each producing one bit per cycle.
// The ROL/ROR opcodes are compiled in only when ALU_ROTATE_EN is defined.
`timescale 1ns/1ps

module alu_seq_core #(
    parameter int                 WIDTH   = 4,
    parameter logic [2*WIDTH-1:0] ENC_KEY = (2*WIDTH)'(8'hAB)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               overflow,
    output logic               div_by_zero,
    output logic               busy
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_AND = 4'd4,
        OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7, OP_ENC = 4'd8, OP_ROL = 4'd9,
        OP_ROR = 4'd10
    } op_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic [2*WIDTH-1:0]   imm_result;
    logic                 imm_carry, imm_ovf, imm_dbz, imm_calc;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, step_next;

`ifdef ALU_ROTATE_EN
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    logic [WIDTH-1:0] rot_amt;
`endif

    // Single-cycle ops, evaluated straight from the ports so the result can register on accept.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        imm_result = '0;
        imm_carry  = 1'b0;
        imm_ovf    = 1'b0;
        imm_dbz    = 1'b0;
        imm_calc   = 1'b0;
        sum        = {1'b0, a} + {1'b0, b};
        diff       = a - b;
`ifdef ALU_ROTATE_EN
        rot_amt    = b % WIDTH_V;
`endif
        case (op)
            OP_ADD: begin
                imm_result = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                imm_carry  = sum[WIDTH];
                imm_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                imm_result = {{WIDTH{1'b0}}, diff};
                imm_carry  = (a >= b);
                imm_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: imm_calc = 1'b1;
            OP_DIV: begin
                if (b == '0) imm_dbz  = 1'b1;
                else         imm_calc = 1'b1;
            end
            OP_AND: imm_result = {{WIDTH{1'b0}}, a & b};
            OP_OR:  imm_result = {{WIDTH{1'b0}}, a | b};
            OP_XOR: imm_result = {{WIDTH{1'b0}}, a ^ b};
            OP_NOT: imm_result = {{WIDTH{1'b0}}, ~a};
            OP_ENC: imm_result = {a, b} ^ ENC_KEY;
`ifdef ALU_ROTATE_EN
            // A shift by WIDTH yields zero, so an amount of 0 leaves a unchanged.
            OP_ROL: imm_result = {{WIDTH{1'b0}}, (a << rot_amt) | (a >> (WIDTH_V - rot_amt))};
            OP_ROR: imm_result = {{WIDTH{1'b0}}, (a >> rot_amt) | (a << (WIDTH_V - rot_amt))};
`endif
            default: ;
        endcase
    end

    // acc_q holds {partial_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = {div_ge ? div_diff : div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        step_next = is_div_q ? div_next : mul_next;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    is_div_d = (op == OP_DIV);
                    opnd_d   = (op == OP_DIV) ? b : a;
                    acc_d    = (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
                    cnt_d    = '0;
                    if (imm_calc) begin
                        state_d  = S_CALC;
                        result_d = '0;
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        dbz_d    = 1'b0;
                    end else begin
                        state_d  = S_DONE;
                        result_d = imm_result;
                        carry_d  = imm_carry;
                        ovf_d    = imm_ovf;
                        dbz_d    = imm_dbz;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = is_div_q ? {step_next[WIDTH-1:0], step_next[2*WIDTH-1:WIDTH]}
                                        : step_next;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q == S_CALC);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: directed vectors on a WIDTH=4 instance plus one WIDTH=8 MUL.
`timescale 1ns/1ps

module tb_alu_seq_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op, a, b;
    logic [7:0]  result;
    logic        carry, overflow, div_by_zero, busy;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;
    logic        carry8, overflow8, div_by_zero8, busy8;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_core #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
        .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy)
    );

    alu_seq_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .carry(carry8),
        .overflow(overflow8), .div_by_zero(div_by_zero8), .busy(busy8)
    );

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        c, v, z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t sb8[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   lat_seen = 1'b0, lat_seen8 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitors: compare the scoreboard head every cycle the result is presented, pop on retirement.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) flag_fail("w4 out_valid with empty scoreboard");
            else begin
                if (!lat_seen) begin
                    check({sb[0].name, " latency"}, cyc - sb[0].acc + 1, sb[0].lat);
                    lat_seen = 1'b1;
                end
                check({sb[0].name, " result"}, {24'd0, result}, {16'd0, sb[0].res});
                check({sb[0].name, " flags cvz"}, {29'd0, carry, overflow, div_by_zero},
                      {29'd0, sb[0].c, sb[0].v, sb[0].z});
                if (out_ready) begin
                    void'(sb.pop_front());
                    lat_seen = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid8) begin
            if (sb8.size() == 0) flag_fail("w8 out_valid with empty scoreboard");
            else begin
                if (!lat_seen8) begin
                    check({sb8[0].name, " latency"}, cyc - sb8[0].acc + 1, sb8[0].lat);
                    lat_seen8 = 1'b1;
                end
                check({sb8[0].name, " result"}, {16'd0, result8}, {16'd0, sb8[0].res});
                check({sb8[0].name, " flags cvz"}, {29'd0, carry8, overflow8, div_by_zero8},
                      {29'd0, sb8[0].c, sb8[0].v, sb8[0].z});
                if (out_ready8) begin
                    void'(sb8.pop_front());
                    lat_seen8 = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                         output int acc);
        bit got = 1'b0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            flag_fail("in_ready wait timed out");
            in_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            in_valid = 1'b0;
            a = 4'($urandom);
            b = 4'($urandom);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] r, input logic c, input logic v,
                        input logic z, input int lat, input int acc);
        exp_t e;
        e.name = nm; e.res = r; e.c = c; e.v = v; e.z = z; e.lat = lat; e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!done) begin
            flag_fail("result retirement timed out");
            sb.delete();
            lat_seen = 1'b0;
        end
        #1;
    endtask

    task automatic send(input string nm, input logic [3:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [15:0] r, input logic c,
                        input logic v, input logic z, input int lat);
        int acc;
        issue(o, x, y, acc);
        if (acc >= 0) push(nm, r, c, v, z, lat, acc);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int  acc;
        bit  got;
        exp_t e8;

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;

        #3;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid/busy", {30'd0, out_valid, busy}, 32'd0);
        check("reset result", {24'd0, result}, 32'd0);
        check("reset flags", {29'd0, carry, overflow, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send("add 9+8", 4'd0, 4'd9, 4'd8, 16'h01, 1'b1, 1'b1, 1'b0, 1);
        send("add 3+4", 4'd0, 4'd3, 4'd4, 16'h07, 1'b0, 1'b0, 1'b0, 1);
        send("add 7+1", 4'd0, 4'd7, 4'd1, 16'h08, 1'b0, 1'b1, 1'b0, 1);
        send("sub 8-1", 4'd1, 4'd8, 4'd1, 16'h07, 1'b1, 1'b1, 1'b0, 1);
        send("sub 5-5", 4'd1, 4'd5, 4'd5, 16'h00, 1'b1, 1'b0, 1'b0, 1);
        send("and", 4'd4, 4'hC, 4'hA, 16'h08, 1'b0, 1'b0, 1'b0, 1);
        send("or",  4'd5, 4'hC, 4'h3, 16'h0F, 1'b0, 1'b0, 1'b0, 1);
        send("xor", 4'd6, 4'hF, 4'h5, 16'h0A, 1'b0, 1'b0, 1'b0, 1);
        send("not", 4'd7, 4'h5, 4'hF, 16'h0A, 1'b0, 1'b0, 1'b0, 1);
        send("unknown op15", 4'd15, 4'hF, 4'hF, 16'h00, 1'b0, 1'b0, 1'b0, 1);

        // MUL 15*15: four busy cycles, in_ready low, and a stray in_valid is ignored.
        issue(4'd2, 4'd15, 4'd15, acc);
        if (acc >= 0) push("mul 15*15", 16'hE1, 1'b0, 1'b0, 1'b0, 5, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul busy in calc", {31'd0, busy}, 32'd1);
            check("mul in_ready in calc", {31'd0, in_ready}, 32'd0);
            if (i == 1) begin
                in_valid = 1'b1; op = 4'd0; a = 4'd1; b = 4'd1;
            end
            if (i == 2) in_valid = 1'b0;
        end
        @(negedge clk);
        check("mul busy after calc", {31'd0, busy}, 32'd0);
        drain();

        send("mul 3*5", 4'd2, 4'd3, 4'd5, 16'h0F, 1'b0, 1'b0, 1'b0, 5);
        send("mul 0*9", 4'd2, 4'd0, 4'd9, 16'h00, 1'b0, 1'b0, 1'b0, 5);
        send("div 13/4", 4'd3, 4'd13, 4'd4, 16'h31, 1'b0, 1'b0, 1'b0, 5);
        send("div 7/0", 4'd3, 4'd7, 4'd0, 16'h00, 1'b0, 1'b0, 1'b1, 1);
        send("div 15/1", 4'd3, 4'd15, 4'd1, 16'hF0, 1'b0, 1'b0, 1'b0, 5);
        send("div 2/7", 4'd3, 4'd2, 4'd7, 16'h02, 1'b0, 1'b0, 1'b0, 5);

        // Backpressure: ENC result held for five cycles, then retired.
        out_ready = 1'b0;
        issue(4'd8, 4'h3, 4'hC, acc);
        if (acc >= 0) push("enc 3,C", 16'h97, 1'b0, 1'b0, 1'b0, 1, acc);
        repeat (5) @(posedge clk);
        #1;
        check("enc out_valid while stalled", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("enc in_ready after retire", {31'd0, in_ready}, 32'd1);
        check("enc out_valid after retire", {31'd0, out_valid}, 32'd0);
        drain();

        // Asynchronous reset in the middle of a DIV.
        issue(4'd3, 4'd13, 4'd4, acc);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("div busy before abort", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort out_valid/busy", {30'd0, out_valid, busy}, 32'd0);
        check("abort result", {24'd0, result}, 32'd0);
        check("abort flags", {29'd0, carry, overflow, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send("sub 3-5", 4'd1, 4'd3, 4'd5, 16'h0E, 1'b0, 1'b0, 1'b0, 1);

`ifdef ALU_ROTATE_EN
        send("rol 9 by 5", 4'd9, 4'b1001, 4'd5, 16'h03, 1'b0, 1'b0, 1'b0, 1);
        send("ror 9 by 1", 4'd10, 4'b1001, 4'd1, 16'h0C, 1'b0, 1'b0, 1'b0, 1);
        send("rol 9 by 4", 4'd9, 4'b1001, 4'd4, 16'h09, 1'b0, 1'b0, 1'b0, 1);
`else
        send("op9 unknown", 4'd9, 4'b1001, 4'd5, 16'h00, 1'b0, 1'b0, 1'b0, 1);
        send("op10 unknown", 4'd10, 4'b1001, 4'd1, 16'h00, 1'b0, 1'b0, 1'b0, 1);
`endif

        // WIDTH=8 MUL regression.
        op8 = 4'd2; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            flag_fail("w8 in_ready wait timed out");
            in_valid8 = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            e8.name = "w8 mul FF*FF"; e8.res = 16'hFE01; e8.c = 1'b0; e8.v = 1'b0; e8.z = 1'b0;
            e8.lat = 9; e8.acc = cyc;
            sb8.push_back(e8);
            got = 1'b0;
            for (int i = 0; i < 60; i++) begin
                if (sb8.size() == 0) begin
                    got = 1'b1;
                    break;
                end
                @(posedge clk);
            end
            if (!got) flag_fail("w8 result retirement timed out");
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
